ntt_seq_ctrl: RTL
=================

// Module: ntt_seq_ctrl
// PURPOSE
//  Sequencer that drives the NTT address generator. Accepts a start/mode request and
//  produces the free-running clk_counter ({stage[2:0], step[4:0]}) the generator decodes.
//  Also produces read/write enables aligned to butterfly pipeline latency and done/busy status.
//  Sits between the top-level Kyber poly-op FSM and addr_gen / butterfly / RAM banks.
// PARAMETERS
//  PIPE_LAT     4  cycles from a read address to its write-back (butterfly + RAM latency), 1..15
//  NTT_STAGES   7  stages for NTT/INVNTT (32 steps each)
//  MULT_STAGES  4  passes for MULT (32 steps each)
//  ADD_STAGES   4  passes for ADDSUB (32 steps each)
// PORTS
//  clk          in   1  system clock, rising edge
//  rst          in   1  synchronous, active-high reset
//  start        in   1  request pulse/level; sampled only when ready=1
//  mode         in   2  0:NTT 1:INVNTT 2:MULT 3:ADDSUB; sampled with start
//  ready        out  1  1 in IDLE and DONE (start accepted)
//  busy         out  1  1 from accepted start until done
//  mode_q       out  2  mode latched at start, held until next start
//  clk_counter  out  8  {stage,step} to addr_gen; 0 outside RUN
//  rd_en        out  1  coefficient/twiddle read valid (RUN state)
//  wr_en        out  1  rd_en delayed by exactly PIPE_LAT cycles
//  stage_done   out  1  1-cycle pulse on last step (step==31) of each stage in RUN
//  done         out  1  1-cycle pulse after final write-back
// BEHAVIOUR
//  Reset: state=IDLE; clk_counter=0, mode_q=0, rd_en=0, wr_en=0 (delay line cleared),
//   busy=0, stage_done=0, done=0, ready=1. Mid-run reset aborts immediately; no done pulse.
//  FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE. All outputs are registered.
//   IDLE: start=1 -> RUN. At next edge: clk_counter=0, rd_en=1, busy=1, mode_q=mode.
//   RUN: clk_counter +1 per cycle. LAST = STAGES(mode_q)*32-1 (NTT 223=0xDF, MULT 127=0x7F).
//    When clk_counter==LAST -> DRAIN. Next edge: clk_counter=0, rd_en=0.
//    Counter never passes LAST, so stage field [7:5] never reaches 7.
//   DRAIN: lasts exactly PIPE_LAT cycles. wr_en keeps flowing from the delay line.
//   DONE: done=1, busy=0, ready=1 for exactly one cycle, then IDLE.
//    start=1 in DONE starts a new run back-to-back (RUN at next edge); done still pulses.
//  start while busy (RUN/DRAIN) is ignored and is not queued; mode changes are ignored too.
//  Per run: rd_en high for LAST+1 cycles; wr_en high for LAST+1 cycles, lagging by PIPE_LAT.
//  busy high for LAST+1+PIPE_LAT cycles.
//  stage_done = rd_en & (clk_counter[4:0]==31), combinational from registered state.
//   Per run it pulses STAGES(mode_q) times.
// CONFIGURATION
//  NTT_SEQ_STALL_EN defined: adds input `stall` (1 bit).
//   While stall=1 in RUN: clk_counter holds, rd_en=0, stage_done=0.
//   The delay line still shifts, so in-flight writes complete.
//   Stall in IDLE/DRAIN/DONE has no effect.
//  Undefined: no stall port; the counter advances unconditionally in RUN.
// STRUCTURE
//  Shared package ntt_pkg:
//   mode encodings MODE_NTT/MODE_INVNTT/MODE_MULT/MODE_ADDSUB
//   STEP_W=5, STAGE_W=3, stage-count constants, FSM state encoding.
//  One sub-module ntt_seq_dly: PIPE_LAT-deep 1-bit shift register, synchronous clear on rst.
//   It generates wr_en from rd_en.
//  Stall-gating sits in the parent only.
// TESTING
//  1. rst=1 for 3 cycles, then 0 -> all outputs 0, ready=1; idle 10 cycles with start=0 -> no change.
//  2. start=1, mode=0 for 1 cycle -> clk_counter 0..223 consecutively; 7 stage_done pulses;
//     rd_en falls after 0xDF; wr_en high 224 cycles starting 4 cycles after rd_en;
//     done 1 cycle at busy+228.
//  3. mode=2 (MULT) -> last count 0x7F, 4 stage_done pulses, busy 132 cycles; mode_q=2 throughout.
//  4. start pulsed with mode=1 at count 50 of an NTT run -> ignored; mode_q stays 0; run length unchanged.
//  5. start held high continuously -> back-to-back runs; done pulse immediately followed by clk_counter=0, rd_en=1.
//  6. rst asserted at count 100 -> next cycle all outputs 0, wr_en line cleared, no done;
//     with NTT_SEQ_STALL_EN, stall 5 cycles at count 40 -> counter holds 40, busy stretched by 5.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT sequencer: counter field widths, pass counts
// per operation, operation and FSM state encodings, and the per-mode last count.
package ntt_pkg;

  localparam int STEP_W      = 5;
  localparam int STAGE_W     = 3;
  localparam int CNT_W       = STAGE_W + STEP_W;
  localparam int STEPS       = 1 << STEP_W;

  localparam int NTT_STAGES  = 7;
  localparam int MULT_STAGES = 4;
  localparam int ADD_STAGES  = 4;

  typedef enum logic [1:0] {
    MODE_NTT    = 2'd0,
    MODE_INVNTT = 2'd1,
    MODE_MULT   = 2'd2,
    MODE_ADDSUB = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Final {stage,step} value of a run: every pass walks all 32 steps.
  function automatic logic [CNT_W-1:0] last_count(input logic [1:0] mode);
    int stages;
    case (mode)
      MODE_NTT, MODE_INVNTT: stages = NTT_STAGES;
      MODE_MULT:             stages = MULT_STAGES;
      default:               stages = ADD_STAGES;
    endcase
    return CNT_W'(stages * STEPS - 1);
  endfunction

endpackage

// File: rtl/ntt_seq_dly.sv
// Fixed-depth 1-bit delay line that turns the read strobe into the write-back
// strobe once data has crossed the butterfly and RAM pipeline.
module ntt_seq_dly
  import ntt_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;

  // Shift one position per cycle; reset flushes any in-flight writes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= (sr_q << 1) | DEPTH'(d_i);
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/ntt_seq_ctrl.sv
// Sequencer for the NTT address generator: accepts a start/mode request, sweeps
// the {stage,step} counter, and produces read/write strobes plus done/busy status.
// Optional build macro NTT_SEQ_STALL_EN adds a stall input that freezes the sweep.
module ntt_seq_ctrl
  import ntt_pkg::*;
#(
  parameter int PIPE_LAT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
`ifdef NTT_SEQ_STALL_EN
  input  logic             stall_i,
`endif
  output logic             ready_o,
  output logic             busy_o,
  output logic [1:0]       mode_q_o,
  output logic [CNT_W-1:0] clk_counter_o,
  output logic             rd_en_o,
  output logic             wr_en_o,
  output logic             stage_done_o,
  output logic             done_o
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       mode_q;
  logic             rd_en_q;
  logic             busy_q;
  logic             ready_q;
  logic             done_q;
  logic [3:0]       drain_q;

  logic             stall_act;
  logic [CNT_W-1:0] last_cnt;

`ifdef NTT_SEQ_STALL_EN
  assign stall_act = stall_i & (state_q == ST_RUN);
`else
  assign stall_act = 1'b0;
`endif

  assign last_cnt = last_count(mode_q);

  // Single FSM: every status output is registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_NTT;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      drain_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            mode_q  <= mode_i;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!stall_act) begin
            if (cnt_q == last_cnt) begin
              state_q <= ST_DRAIN;
              cnt_q   <= '0;
              rd_en_q <= 1'b0;
              drain_q <= 4'(PIPE_LAT - 1);
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_en_o       = rd_en_q & ~stall_act;
  assign stage_done_o  = rd_en_o & (cnt_q[STEP_W-1:0] == {STEP_W{1'b1}});
  assign ready_o       = ready_q;
  assign busy_o        = busy_q;
  assign mode_q_o      = mode_q;
  assign clk_counter_o = cnt_q;
  assign done_o        = done_q;

  ntt_seq_dly #(
    .DEPTH(PIPE_LAT)
  ) u_dly (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (rd_en_o),
    .q_o  (wr_en_o)
  );

endmodule
